pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// ----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Supervises the pixel-clock PLL from the board-clock domain. After power-up
// or on request the PLL is held in reset for a fixed interval. The sequencer
// then waits for lock and requires lock to be stable for a qualification
// window before the video-domain reset is released. A lock that never arrives
// is treated as a timeout and the PLL is reset again. Lock losses and
// timeouts are counted (saturating) for debug.
//
// Parameters
//   PLL_RESET_CYCLES    cycles pll_resetb is held low per reset pulse (>=1)
//   LOCK_TIMEOUT_CYCLES cycles allowed in WAIT_LOCK before the PLL is reset
//   LOCK_STABLE_CYCLES  consecutive locked cycles required before release
//   CNT_W               timer width; must hold the largest cycle parameter
//
// Ports
//   clock_in      in   board clock, also the PLL reference clock
//   reset_n       in   asynchronous active-low reset
//   locked        in   PLL lock indicator, asynchronous to clock_in
//   relock_req    in   single-cycle request for a full PLL reset/relock
//   pll_resetb    out  PLL RESETB; 0 holds the PLL in reset
//   sys_reset_n   out  active-low reset for the video logic
//   ready         out  1 while in RUN
//   state         out  0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   relock_count  out  RUN lock-loss events, saturating at 255
//   timeout_count out  WAIT_LOCK timeouts, saturating at 255
// ----------------------------------------------------------------------------
module pll_lock_sequencer #(
   parameter int PLL_RESET_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 100000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int CNT_W               = 17
) (
   input  logic       clock_in,
   input  logic       reset_n,
   input  logic       locked,
   input  logic       relock_req,
   output logic       pll_resetb,
   output logic       sys_reset_n,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] relock_count,
   output logic [7:0] timeout_count
);

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   // Terminal timer values: each state is left on the cycle its timer reads
   // the last value of its interval.
   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

   state_t           state_q;
   state_t           state_nxt;
   logic [CNT_W-1:0] timer_q;
   logic             timer_clr;
   logic             inc_relock;
   logic             inc_timeout;

   // Two-flop synchronizer for the asynchronous lock indicator.
   logic             lock_meta;
   logic             lock_s;

   // Saturating 8-bit increment: debug counters stick at 255 rather than wrap.
   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

   // -------------------------------------------------------------------------
   // Next-state decode
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first so no path leaves it
   // unassigned; otherwise synthesis would infer a latch to hold its value.
   always_comb begin
      state_nxt   = state_q;
      inc_relock  = 1'b0;
      inc_timeout = 1'b0;

      if (relock_req) begin
         // A relock request overrides everything. A lock loss seen in RUN on
         // the same cycle is still a lock-loss event and is counted once.
         state_nxt = PLL_RST;
         if (state_q == RUN && !lock_s) begin
            inc_relock = 1'b1;
         end
      end else begin
         unique case (state_q)
            PLL_RST: begin
               if (timer_q == RST_LAST) begin
                  state_nxt = WAIT_LOCK;
               end
            end

            WAIT_LOCK: begin
               // Lock takes precedence over a timeout on the same cycle.
               if (lock_s) begin
                  state_nxt = STABLE;
               end else if (timer_q == TIMEOUT_LAST) begin
                  state_nxt   = PLL_RST;
                  inc_timeout = 1'b1;
               end
            end

            STABLE: begin
               // Any drop restarts qualification from WAIT_LOCK; this is a
               // lock that never settled, not a lock loss, so it is not counted.
               if (!lock_s) begin
                  state_nxt = WAIT_LOCK;
               end else if (timer_q == STABLE_LAST) begin
                  state_nxt = RUN;
               end
            end

            RUN: begin
               if (!lock_s) begin
                  state_nxt  = WAIT_LOCK;
                  inc_relock = 1'b1;
               end
            end

            default: begin
               state_nxt = PLL_RST;
            end
         endcase
      end

      // The timer restarts on every state entry. A relock request in PLL_RST
      // re-enters the same state, so it must clear the timer explicitly.
      timer_clr = relock_req || (state_nxt != state_q);
   end

   // -------------------------------------------------------------------------
   // State, timer, synchronizer, counters and registered outputs
   // -------------------------------------------------------------------------
   // Outputs are decoded from the next state so that they change on the same
   // edge as the state they describe, without any combinational output path.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of statement order.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta     <= 1'b0;
         lock_s        <= 1'b0;
         state_q       <= PLL_RST;
         timer_q       <= '0;
         pll_resetb    <= 1'b0;
         sys_reset_n   <= 1'b0;
         ready         <= 1'b0;
         relock_count  <= 8'd0;
         timeout_count <= 8'd0;
      end else begin
         lock_meta <= locked;
         lock_s    <= lock_meta;

         state_q <= state_nxt;

         // In RUN the timer keeps counting and may wrap; nothing in RUN
         // looks at it, so the wrap is harmless.
         if (timer_clr) begin
            timer_q <= '0;
         end else begin
            timer_q <= timer_q + CNT_W'(1);
         end

         pll_resetb  <= (state_nxt != PLL_RST);
         sys_reset_n <= (state_nxt == RUN);
         ready       <= (state_nxt == RUN);

         if (inc_relock) begin
            relock_count <= sat_inc(relock_count);
         end
         if (inc_timeout) begin
            timeout_count <= sat_inc(timeout_count);
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Self-checking bench for pll_lock_sequencer with PLL_RESET_CYCLES=4,
// LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=8. Inputs change and outputs are
// sampled on the falling edge; each table row covers one rising edge.
// ----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

   logic       clock_in;
   logic       reset_n;
   logic       locked;
   logic       relock_req;
   logic       pll_resetb;
   logic       sys_reset_n;
   logic       ready;
   logic [1:0] state;
   logic [7:0] relock_count;
   logic [7:0] timeout_count;

   int n_cmp  = 0;
   int n_fail = 0;

   pll_lock_sequencer #(
      .PLL_RESET_CYCLES   (4),
      .LOCK_TIMEOUT_CYCLES(50),
      .LOCK_STABLE_CYCLES (8),
      .CNT_W              (17)
   ) dut (
      .clock_in     (clock_in),
      .reset_n      (reset_n),
      .locked       (locked),
      .relock_req   (relock_req),
      .pll_resetb   (pll_resetb),
      .sys_reset_n  (sys_reset_n),
      .ready        (ready),
      .state        (state),
      .relock_count (relock_count),
      .timeout_count(timeout_count)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   typedef struct {
      logic       locked;
      logic       relock_req;
      logic [1:0] st;
      logic       prb;
      logic       srn;
      logic       rdy;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One rising edge; called and returns on a falling edge.
   task automatic step();
      @(posedge clock_in);
      @(negedge clock_in);
   endtask

   task automatic add(input int n, input logic l, input logic r,
                      input logic [1:0] st, input logic p, input logic s,
                      input logic rd);
      vec_t v;
      v.locked = l; v.relock_req = r; v.st = st;
      v.prb = p; v.srn = s; v.rdy = rd;
      repeat (n) vq.push_back(v);
   endtask

   task automatic run_vectors(input string tag);
      foreach (vq[i]) begin
         locked     = vq[i].locked;
         relock_req = vq[i].relock_req;
         step();
         check($sformatf("%s[%0d].state", tag, i), 32'(state), 32'(vq[i].st));
         check($sformatf("%s[%0d].pll_resetb", tag, i), 32'(pll_resetb), 32'(vq[i].prb));
         check($sformatf("%s[%0d].sys_reset_n", tag, i), 32'(sys_reset_n), 32'(vq[i].srn));
         check($sformatf("%s[%0d].ready", tag, i), 32'(ready), 32'(vq[i].rdy));
      end
      relock_req = 1'b0;
      vq.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".state"}, 32'(state), 32'd0);
      check({tag, ".pll_resetb"}, 32'(pll_resetb), 32'd0);
      check({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'd0);
      check({tag, ".ready"}, 32'(ready), 32'd0);
      check({tag, ".relock_count"}, 32'(relock_count), 32'd0);
      check({tag, ".timeout_count"}, 32'(timeout_count), 32'd0);
   endtask

   // Holds reset over two edges, checks reset values, releases on a falling edge.
   task automatic do_reset(input string tag);
      reset_n    = 1'b0;
      locked     = 1'b0;
      relock_req = 1'b0;
      repeat (2) @(negedge clock_in);
      check_reset_outputs(tag);
      reset_n = 1'b1;
   endtask

   // Steps until state==st; an expired budget is reported as a failure.
   task automatic wait_state(input logic [1:0] st, input int budget,
                             input string name);
      int n = 0;
      while (state != st && n < budget) begin
         step();
         n++;
      end
      if (state != st) check(name, 32'(state), 32'(st));
   endtask

   initial begin
      reset_n    = 1'b0;
      locked     = 1'b0;
      relock_req = 1'b0;

      // 1. Power-up: lock rises 10 cycles after reset release (sampled at
      //    edge 11); RUN and sys_reset_n=1 at edge 21.
      do_reset("rst1");
      add(3, 0, 0, 2'd0, 0, 0, 0);   // edges 1-3   PLL held in reset
      add(7, 0, 0, 2'd1, 1, 0, 0);   // edges 4-10  WAIT_LOCK
      add(2, 1, 0, 2'd1, 1, 0, 0);   // edges 11-12 synchronizer latency
      add(8, 1, 0, 2'd2, 1, 0, 0);   // edges 13-20 STABLE
      add(2, 1, 0, 2'd3, 1, 1, 1);   // edges 21-22 RUN
      run_vectors("powerup");

      // 2. Never locks: timeouts at edges 54, 108, 162; each followed by a
      //    4-cycle pll_resetb pulse.
      do_reset("rst2");
      for (int e = 1; e <= 200; e++) begin
         logic exp_low;
         step();
         exp_low = (e <= 3) || (e >= 54 && ((e - 54) % 54) < 4);
         check($sformatf("nolock[%0d].pll_resetb", e), 32'(pll_resetb), 32'(!exp_low));
         check($sformatf("nolock[%0d].sys_reset_n", e), 32'(sys_reset_n), 32'd0);
         if (e == 53)  check("nolock.timeout_count@53", 32'(timeout_count), 32'd0);
         if (e == 54)  check("nolock.timeout_count@54", 32'(timeout_count), 32'd1);
         if (e == 200) check("nolock.timeout_count@200", 32'(timeout_count), 32'd3);
      end

      // 3. Lock chatter: high 5, low 2, high 20 -> STABLE aborts at edge 14,
      //    final rise sampled at edge 14, RUN at edge 24.
      do_reset("rst3");
      add(3, 0, 0, 2'd0, 0, 0, 0);   // edges 1-3
      add(3, 0, 0, 2'd1, 1, 0, 0);   // edges 4-6
      add(2, 1, 0, 2'd1, 1, 0, 0);   // edges 7-8
      add(3, 1, 0, 2'd2, 1, 0, 0);   // edges 9-11
      add(2, 0, 0, 2'd2, 1, 0, 0);   // edges 12-13 drop not yet visible
      add(2, 1, 0, 2'd1, 1, 0, 0);   // edges 14-15 aborted to WAIT_LOCK
      add(8, 1, 0, 2'd2, 1, 0, 0);   // edges 16-23
      add(10, 1, 0, 2'd3, 1, 1, 1);  // edges 24-33
      run_vectors("chatter");
      check("chatter.relock_count", 32'(relock_count), 32'd0);
      check("chatter.timeout_count", 32'(timeout_count), 32'd0);

      // 4. Lock loss in RUN: locked low at edges 34-36, sys_reset_n drops at
      //    edge 36, returns sampled at edge 37, RUN at edge 47.
      add(2, 0, 0, 2'd3, 1, 1, 1);   // edges 34-35
      add(1, 0, 0, 2'd1, 1, 0, 0);   // edge 36
      add(2, 1, 0, 2'd1, 1, 0, 0);   // edges 37-38
      add(8, 1, 0, 2'd2, 1, 0, 0);   // edges 39-46
      add(2, 1, 0, 2'd3, 1, 1, 1);   // edges 47-48
      run_vectors("loss");
      check("loss.relock_count", 32'(relock_count), 32'd1);

      // 5. relock_req on the edge where lock_s=0 is first seen in RUN.
      add(2, 0, 0, 2'd3, 1, 1, 1);   // edges 49-50
      add(1, 0, 1, 2'd0, 0, 0, 0);   // edge 51 request + lock loss
      add(3, 0, 0, 2'd0, 0, 0, 0);   // edges 52-54
      add(1, 0, 0, 2'd1, 1, 0, 0);   // edge 55
      run_vectors("reqloss");
      check("reqloss.relock_count", 32'(relock_count), 32'd2);
      check("reqloss.timeout_count", 32'(timeout_count), 32'd0);

      // 6. 260 lock losses saturate relock_count, then reset mid-STABLE.
      do_reset("rst6");
      locked = 1'b1;
      wait_state(2'd3, 40, "sat.first_run");
      for (int i = 1; i <= 260; i++) begin
         locked = 1'b0;
         step();
         locked = 1'b1;
         wait_state(2'd1, 10, $sformatf("sat[%0d].to_wait", i));
         wait_state(2'd3, 30, $sformatf("sat[%0d].to_run", i));
         if (i == 200) check("sat.relock_count@200", 32'(relock_count), 32'd200);
         if (i == 255) check("sat.relock_count@255", 32'(relock_count), 32'd255);
      end
      check("sat.relock_count@260", 32'(relock_count), 32'd255);
      check("sat.timeout_count", 32'(timeout_count), 32'd0);

      locked = 1'b0;
      step();
      locked = 1'b1;
      wait_state(2'd2, 10, "midstable.to_stable");
      check("midstable.state_before", 32'(state), 32'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midstable");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
